// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide; one bit per cycle.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2:0]        op_q;
  logic [XLEN-1:0]   b_q;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              sa_q;
  logic              sb_q;
  logic [XLEN-1:0]   result_q;

  logic            accept;
  logic            a_signed;
  logic            b_signed;
  logic            sgn_a;
  logic            sgn_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            b_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] special_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_nxt;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  assign accept = i_start &&
    ((state == S_IDLE) || (state == S_DONE));

  // operand signedness per funct3
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (1'b1)
      (i_op == 3'd1),
      (i_op == 3'd4),
      (i_op == 3'd6): begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      (i_op == 3'd2): a_signed = 1'b1;
      default: ;
    endcase
  end

  assign sgn_a = a_signed & i_a[XLEN-1];
  assign sgn_b = b_signed & i_b[XLEN-1];
  assign mag_a = sgn_a ? (~i_a + 1'b1) : i_a;
  assign mag_b = sgn_b ? (~i_b + 1'b1) : i_b;

  always_comb begin
    b_zero      = (i_b == '0);
    ovf         = (i_a == MIN_NEG) && (i_b == '1) &&
                  ((i_op == 3'd4) || (i_op == 3'd6));
    special     = i_op[2] && (b_zero || ovf);
    special_res = '0;
    if (b_zero) begin
      special_res = i_op[1] ? i_a : '1;
    end else if (ovf) begin
      special_res = i_op[1] ? '0 : MIN_NEG;
    end
  end

  // acc = {partial product, multiplier} while multiplying
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]};
    if (acc[0]) begin
      mul_sum = mul_sum + {1'b0, b_q};
    end
    mul_nxt = {mul_sum, acc[XLEN-1:1]};
  end

  // acc = {remainder, dividend/quotient} while dividing
  always_comb begin
    div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (div_diff[XLEN]) begin
      div_nxt = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      div_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  always_comb begin
    prod = (sa_q ^ sb_q) ? (~acc + 1'b1) : acc;
    quo  = (sa_q ^ sb_q) ?
           (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem  = sa_q ?
           (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    unique case (op_q)
      3'd0:             fix_res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fix_res = quo;
      default:          fix_res = rem;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_nxt = special ? S_DONE : S_CALC;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt == '0) begin
          state_nxt = S_FIX;
        end
      end
      S_FIX:   state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy   = (state == S_CALC) || (state == S_FIX);
    o_done   = (state == S_DONE);
    o_result = result_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q     <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q <= i_op;
      sa_q <= sgn_a;
      sb_q <= sgn_b;
      b_q  <= mag_b;
      acc  <= {{XLEN{1'b0}}, mag_a};
      cnt  <= CW'(XLEN - 1);
      if (special) begin
        result_q <= special_res;
      end
    end else if (state == S_CALC) begin
      acc <= op_q[2] ? div_nxt : mul_nxt;
      cnt <= cnt - CW'(1);
    end else if (state == S_FIX) begin
      result_q <= fix_res;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit.
// Random and directed ops against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(
    input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (f)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == MIN_NEG && y == 32'hFFFF_FFFF) return MIN_NEG;
        p = sx / sy;
        return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == MIN_NEG && y == 32'hFFFF_FFFF) return 32'h0;
        p = sx % sy;
        return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_latency(
    input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && y == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && x == MIN_NEG && y == 32'hFFFF_FFFF)
      return 1;
    return XLEN + 2;
  endfunction

  // Issues one op; lat is the cycle index (1 = cycle after the
  // accepting edge) at which o_done was seen, -1 if never.
  task automatic do_op(input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, output logic [31:0] res,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; op = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
    lat = -1; busy_cnt = 0; res = 'x;
    for (int n = 1; n <= 100; n++) begin
      if (busy) busy_cnt++;
      if (done) begin
        lat = n; res = result;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b want 0", busy);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done got %b want 0", done);
    end
    n_checks++;
    if (result !== 32'h0) begin
      n_fail++; $display("FAIL reset_result got %h want 0", result);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [12] = '{0, 1, 2, 3, 4, 6, 5, 7, 5, 7, 4, 6};
    logic [31:0] t_a  [12] = '{32'd7, MIN_NEG, 32'hFFFF_FFFF,
      32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
      32'd5, 32'd5, MIN_NEG, MIN_NEG};
    logic [31:0] t_b  [12] = '{32'hFFFF_FFFD, MIN_NEG, 32'hFFFF_FFFF,
      32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
      32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_exp[12] = '{32'hFFFF_FFEB, 32'h4000_0000,
      32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
      32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, MIN_NEG, 32'd0};
    logic [31:0] res;
    int lat;
    int bc;
    for (int i = 0; i < 12; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], res, lat, bc);
      n_checks++;
      if (res !== t_exp[i]) begin
        n_fail++;
        $display("FAIL dir%0d_result op=%0d got %h want %h",
                 i, t_op[i], res, t_exp[i]);
      end
      n_checks++;
      if (lat !== ((i < 8) ? 34 : 1)) begin
        n_fail++;
        $display("FAIL dir%0d_latency got %0d want %0d",
                 i, lat, (i < 8) ? 34 : 1);
      end
      n_checks++;
      if (bc !== ((i < 8) ? 33 : 0)) begin
        n_fail++;
        $display("FAIL dir%0d_busy_cycles got %0d want %0d",
                 i, bc, (i < 8) ? 33 : 0);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic [31:0] exp_r;
    int lat;
    int bc;
    int exp_l;
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'h0;
        1: begin x = MIN_NEG; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom_range(0, 300); y = $urandom_range(1, 20); end
        3: y = 32'($signed(-$urandom_range(1, 50)));
        default: ;
      endcase
      exp_r = ref_result(f, x, y);
      exp_l = ref_latency(f, x, y);
      do_op(f, x, y, res, lat, bc);
      n_checks++;
      if (res !== exp_r) begin
        n_fail++;
        $display("FAIL rand%0d_result op=%0d a=%h b=%h got %h want %h",
                 i, f, x, y, res, exp_r);
      end
      n_checks++;
      if (lat !== exp_l) begin
        n_fail++;
        $display("FAIL rand%0d_latency op=%0d got %0d want %0d",
                 i, f, lat, exp_l);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] exp_r;
    logic [31:0] res;
    int lat = -1;
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; b = 32'h0000_1234;
    exp_r = ref_result(3'd5, 32'hDEAD_BEEF, 32'h0000_1234);
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (n >= 5 && n < 9) begin
        start = 1'b1; op = 3'd4; a = $urandom; b = 32'h0;
      end else begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
      if (done) begin
        lat = n; res = result;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_checks++;
    if (lat !== 34) begin
      n_fail++; $display("FAIL ignore_latency got %0d want 34", lat);
    end
    n_checks++;
    if (res !== exp_r) begin
      n_fail++; $display("FAIL ignore_result got %h want %h", res, exp_r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1 = $urandom;
    logic [31:0] b1 = $urandom;
    logic [31:0] a2 = $urandom;
    logic [31:0] b2 = $urandom | 32'h1;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] r1 = 'x;
    logic [31:0] r2 = 'x;
    logic busy_after = 1'b0;
    int d1 = -1;
    int d2 = -1;
    int pulses = 0;
    e1 = ref_result(3'd3, a1, b1);
    e2 = ref_result(3'd5, a2, b2);
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = a1; b = b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 110; n++) begin
      if (d1 > 0 && n == d1 + 1) begin
        start = 1'b0; busy_after = busy;
      end
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          d1 = n; r1 = result; op = 3'd5; a = a2; b = b2;
        end else if (pulses == 2) begin
          d2 = n; r2 = result;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_checks++;
    if (d1 !== 34) begin
      n_fail++; $display("FAIL b2b_first_done got %0d want 34", d1);
    end
    n_checks++;
    if (d2 !== 68) begin
      n_fail++; $display("FAIL b2b_second_done got %0d want 68", d2);
    end
    n_checks++;
    if (pulses !== 2) begin
      n_fail++; $display("FAIL b2b_pulses got %0d want 2", pulses);
    end
    n_checks++;
    if (busy_after !== 1'b1) begin
      n_fail++; $display("FAIL b2b_no_bubble busy got %b want 1", busy_after);
    end
    n_checks++;
    if (r1 !== e1) begin
      n_fail++; $display("FAIL b2b_result1 got %h want %h", r1, e1);
    end
    n_checks++;
    if (r2 !== e2) begin
      n_fail++; $display("FAIL b2b_result2 got %h want %h", r2, e2);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int lat;
    int bc;
    int seen = 0;
    do_op(3'd0, 32'd5, 32'd5, res, lat, bc);
    n_checks++;
    if (res !== 32'd25) begin
      n_fail++; $display("FAIL pre_reset_result got %h want 19", res);
    end
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_busy got %b want 0", busy);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_done got %b want 0", done);
    end
    n_checks++;
    if (result !== 32'h0) begin
      n_fail++; $display("FAIL midrst_result got %h want 0", result);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL midrst_stray_done got %0d want 0", seen);
    end
    do_op(3'd0, 32'd3, 32'd4, res, lat, bc);
    n_checks++;
    if (res !== 32'd12) begin
      n_fail++; $display("FAIL postrst_result got %h want c", res);
    end
    n_checks++;
    if (lat !== 34) begin
      n_fail++; $display("FAIL postrst_latency got %0d want 34", lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
